// File: rtl/bus_xfer_arbiter_if.sv
// Handshake and bus-control bundle between the requesters and the transfer arbiter.
// master = requester side, slave = arbiter side.
interface bus_xfer_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_src;
  logic [4*NREQ-1:0] req_dst;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [3:0]        mux_sel;
  logic [15:0]       ld_en;
  logic              mem_rd;
  logic              busy;

  modport master (
    output req, req_src, req_dst,
    input  gnt, done, err, mux_sel, ld_en, mem_rd, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output gnt, done, err, mux_sel, ld_en, mem_rd, busy
  );
endinterface

// File: rtl/bus_xfer_arbiter.sv
// Round-robin sequencer for the shared 8-bit processor bus: grants one register
// transfer at a time, drives Bus_mux select, inserts MEM read wait states, strobes the load.
module bus_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  bus_xfer_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEL, WAIT, LOAD} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [3:0]        src_q, src_d;
  logic [3:0]        dst_q, dst_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        mux_sel_q, mux_sel_d;
  logic              illegal_q, illegal_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic [15:0]       ld_en_q, ld_en_d;

  logic              found;
  logic [PW-1:0]     pick;
  logic [3:0]        pick_src, pick_dst;

  // First requester at or after ptr, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
    pick_src = bus.req_src[4*int'(pick) +: 4];
    pick_dst = bus.req_dst[4*int'(pick) +: 4];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    mux_sel_d = mux_sel_q;
    illegal_d = illegal_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    mem_rd_d  = 1'b0;
    ld_en_d   = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          win_d     = pick;
          src_d     = pick_src;
          dst_d     = pick_dst;
          mux_sel_d = pick_src;
          illegal_d = (pick_src == 4'hF) || (pick_dst == 4'hF) || (pick_src == pick_dst);
          gnt_d     = NREQ'(1) << pick;
          // Outputs are registered, so the SEL-cycle read strobe is set on entry.
          mem_rd_d  = (pick_src == 4'h0) && !illegal_d;
          state_d   = SEL;
        end
      end
      SEL: begin
        if (!illegal_q && (src_q == 4'h0) && (MEM_LAT != 0)) begin
          cnt_d   = 4'(MEM_LAT);
          state_d = WAIT;
        end else begin
          state_d = LOAD;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = LOAD;
      end
      LOAD: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion strobes are launched on the edge that enters LOAD.
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      done_d  = gnt_q;
      err_d   = illegal_q;
      ld_en_d = illegal_q ? 16'h0 : (16'(1) << dst_q);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      src_q     <= 4'h0;
      dst_q     <= 4'h0;
      cnt_q     <= 4'h0;
      mux_sel_q <= 4'h0;
      illegal_q <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      mem_rd_q  <= 1'b0;
      ld_en_q   <= 16'h0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
      illegal_q <= illegal_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mem_rd_q  <= mem_rd_d;
      ld_en_q   <= ld_en_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.mux_sel = mux_sel_q;
  assign bus.ld_en   = ld_en_q;
  assign bus.mem_rd  = mem_rd_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Directed bench for bus_xfer_arbiter: transfer-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_bus_xfer_arbiter;
  localparam int NREQ    = 4;
  localparam int MEM_LAT = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  bus_xfer_arbiter_if #(.NREQ(NREQ)) bus ();

  bus_xfer_arbiter #(.NREQ(NREQ), .MEM_LAT(MEM_LAT)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: a grant lasts m_len cycles (SEL .. LOAD), age counts from 1.
  bit              m_active = 1'b0;
  int              m_win    = 0;
  int              m_ptr    = 0;
  int              m_age    = 0;
  int              m_len    = 0;
  logic [3:0]      m_src    = 4'h0;
  logic [3:0]      m_dst    = 4'h0;
  logic [3:0]      m_mux    = 4'h0;
  bit              m_ok     = 1'b0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_mux    = 4'h0;
      m_age    = 0;
    end else if (!m_active) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!m_active && bus.req[(m_ptr + i) % NREQ]) begin
          m_active = 1'b1;
          m_win    = (m_ptr + i) % NREQ;
        end
      end
      if (m_active) begin
        m_src = bus.req_src[4*m_win +: 4];
        m_dst = bus.req_dst[4*m_win +: 4];
        m_ok  = (m_src != 4'hF) && (m_dst != 4'hF) && (m_src != m_dst);
        m_len = (m_ok && m_src == 4'h0) ? 2 + MEM_LAT : 2;
        m_age = 1;
        m_mux = m_src;
      end
    end else if (m_age == m_len) begin
      m_active = 1'b0;
      m_ptr    = (m_win + 1) % NREQ;
    end else begin
      m_age++;
    end
  end

  always @(negedge Clk) begin
    logic            load;
    logic [NREQ-1:0] oh;
    if (!Rst) begin
      load = m_active && (m_age == m_len);
      oh   = NREQ'(1) << m_win;
      chk("m_gnt",    32'(bus.gnt),     32'(m_active ? oh : '0));
      chk("m_busy",   32'(bus.busy),    32'(m_active));
      chk("m_mux",    32'(bus.mux_sel), 32'(m_mux));
      chk("m_mem_rd", 32'(bus.mem_rd),  32'(m_active && m_age == 1 && m_ok && m_src == 4'h0));
      chk("m_done",   32'(bus.done),    32'(load ? oh : '0));
      chk("m_err",    32'(bus.err),     32'(load && !m_ok));
      chk("m_ld_en",  32'(bus.ld_en),   32'((load && m_ok) ? (16'(1) << m_dst) : 16'h0));
      chk("m_onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_slot(input int s, input logic [3:0] src, input logic [3:0] dst);
    bus.req_src[4*s +: 4] = src;
    bus.req_dst[4*s +: 4] = dst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int wt;
    bus.req     = '0;
    bus.req_src = '0;
    bus.req_dst = '0;

    #12;
    chk("rst_gnt",  32'(bus.gnt),     32'h0);
    chk("rst_busy", 32'(bus.busy),    32'h0);
    chk("rst_mux",  32'(bus.mux_sel), 32'h0);
    chk("rst_ld",   32'(bus.ld_en),   32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    cyc(1);

    // Single request: AC -> DR on slot 1
    set_slot(1, 4'd14, 4'd2);
    bus.req = 4'b0010;
    cyc(1);
    chk("s1_gnt",  32'(bus.gnt),     32'h2);
    chk("s1_mux",  32'(bus.mux_sel), 32'd14);
    chk("s1_busy", 32'(bus.busy),    32'h1);
    cyc(1);
    chk("s1_ld",   32'(bus.ld_en),   32'h0004);
    chk("s1_done", 32'(bus.done),    32'h2);
    bus.req = '0;
    cyc(1);
    chk("s1_idle", 32'(bus.busy),    32'h0);
    cyc(1);

    // MEM read on slot 0 with two wait states
    set_slot(0, 4'd0, 4'd1);
    bus.req = 4'b0001;
    cyc(1);
    chk("m_sel_gnt", 32'(bus.gnt),    32'h1);
    chk("m_sel_rd",  32'(bus.mem_rd), 32'h1);
    cyc(1);
    chk("m_w1_rd",   32'(bus.mem_rd), 32'h0);
    chk("m_w1_ld",   32'(bus.ld_en),  32'h0);
    cyc(2);
    chk("m_ld",      32'(bus.ld_en),  32'h0002);
    chk("m_done",    32'(bus.done),   32'h1);
    chk("m_noerr",   32'(bus.err),    32'h0);
    bus.req = '0;
    cyc(2);

    // Reset during the MEM wait, same request regranted afterwards
    set_slot(0, 4'd0, 4'd4);
    bus.req = 4'b0001;
    cyc(2);
    #2 Rst = 1'b1;
    #1;
    chk("r_gnt",  32'(bus.gnt),     32'h0);
    chk("r_busy", 32'(bus.busy),    32'h0);
    chk("r_done", 32'(bus.done),    32'h0);
    chk("r_mux",  32'(bus.mux_sel), 32'h0);
    chk("r_rd",   32'(bus.mem_rd),  32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    cyc(1);
    chk("r_regnt", 32'(bus.gnt),    32'h1);
    cyc(3);
    chk("r_ld",    32'(bus.ld_en),  32'h0010);
    chk("r_done2", 32'(bus.done),   32'h1);
    bus.req = '0;
    cyc(1);
    #2 Rst = 1'b1;
    #2 Rst = 1'b0;
    cyc(1);

    // Round robin with all four requests held
    for (int s = 0; s < NREQ; s++) set_slot(s, 4'(s + 1), 4'(s + 5));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wt = 0;
      while (bus.gnt == '0 && wt < 10) begin cyc(1); wt++; end
      if (wt == 10) begin
        n_cmp++; n_err++;
        $display("FAIL rr_grant_timeout: no grant within 10 cycles, expected grant %0d", k);
      end
      chk("rr_order", 32'(bus.gnt), 32'(4'b0001 << exp_order[k]));
      wt = 0;
      while (bus.done == '0 && wt < 10) begin cyc(1); wt++; end
      if (wt == 10) begin
        n_cmp++; n_err++;
        $display("FAIL rr_done_timeout: no done within 10 cycles, expected done %0d", k);
      end
      chk("rr_done", 32'(bus.done), 32'(4'b0001 << exp_order[k]));
      cyc(1);
    end
    bus.req = '0;
    cyc(2);

    // Illegal: src == dst
    set_slot(2, 4'd5, 4'd5);
    bus.req = 4'b0100;
    cyc(2);
    chk("il1_done", 32'(bus.done),  32'h4);
    chk("il1_err",  32'(bus.err),   32'h1);
    chk("il1_ld",   32'(bus.ld_en), 32'h0);
    bus.req = '0;
    cyc(2);

    // Illegal: src == 15
    set_slot(3, 4'd15, 4'd3);
    bus.req = 4'b1000;
    cyc(2);
    chk("il2_done", 32'(bus.done),  32'h8);
    chk("il2_err",  32'(bus.err),   32'h1);
    chk("il2_ld",   32'(bus.ld_en), 32'h0);
    bus.req = '0;
    cyc(2);

    // Illegal MEM source with dst == 15: no read strobe
    set_slot(1, 4'd0, 4'd15);
    bus.req = 4'b0010;
    cyc(1);
    chk("il3_rd",  32'(bus.mem_rd), 32'h0);
    cyc(1);
    chk("il3_err", 32'(bus.err),    32'h1);
    bus.req = '0;
    cyc(2);

    // Request dropped in SEL still completes
    set_slot(1, 4'd3, 4'd14);
    bus.req = 4'b0010;
    cyc(1);
    bus.req = '0;
    cyc(1);
    chk("dr_ld",   32'(bus.ld_en), 32'h4000);
    chk("dr_done", 32'(bus.done),  32'h2);
    cyc(1);
    chk("dr_idle", 32'(bus.busy),  32'h0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_xfer_arbiter.md
# bus_xfer_arbiter

Sequencer and arbiter for the shared 8-bit processor bus in the pointcloud core. It accepts register-transfer requests from up to NREQ requesters and grants one at a time in round-robin order. For the granted transfer it drives the 4-bit Bus_mux select, inserts memory read wait states when the source is MEM, and then issues a one-hot destination load strobe. It sits between the instruction decode/control units and the Bus_mux plus register file.

## Interface
- NREQ, 4, number of requesters (2..8)
- MEM_LAT, 2, wait cycles after mem_rd before MEM data is valid on the bus (0..15)
- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester transfer request; held high until that requester's done
- req_src  in  4*NREQ  packed source codes, slot i = bits [4i+3:4i]
- req_dst  in  4*NREQ  packed destination codes, same packing
- gnt  out  NREQ  one-hot grant; high for the whole transfer
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse with done when the transfer was illegal
- mux_sel  out  4  Bus_mux select
- ld_en  out  16  one-hot destination load strobe, bit k = code k
- mem_rd  out  1  one-cycle memory read strobe
- busy  out  1  high whenever state != IDLE

## Operation
- Register codes for both source and destination: 0 MEM, 1 AR, 2 DR, 3 RP, 4 RT, 5 RM1, 6 RK1, 7 RN1, 8 RM2, 9 RK2, 10 RN2, 11 C1, 12 C2, 13 C3, 14 AC, 15 illegal. A destination of 0 means a MEM write.
- FSM states: IDLE, SEL, WAIT, LOAD.
- IDLE: if any req bit is high, pick the winner by round-robin starting at pointer ptr. Latch the winner's src and dst codes, set gnt, and go to SEL. If no req is high, stay in IDLE.
- SEL (1 cycle): mux_sel = latched src.
  - If src = 0: mem_rd = 1 this cycle, load counter with MEM_LAT, and go to WAIT (or straight to LOAD if MEM_LAT = 0).
  - Otherwise: go to LOAD.
- WAIT: decrement the counter each cycle; go to LOAD after the cycle in which the counter reads 1.
- LOAD (1 cycle): ld_en[dst] = 1 and done[winner] = 1. Next state is IDLE, where gnt clears and ptr = (winner+1) mod NREQ.
- Illegal transfer: src = 15, dst = 15, or src = dst. The sequence is IDLE -> SEL -> LOAD with no mem_rd and ld_en = 0. done and err pulse in LOAD.
- mux_sel holds the last latched source between transfers.
- req changes after grant are ignored until IDLE; the transfer always completes.
- A req still high in the first IDLE cycle after done counts as a new request, subject to round-robin.
- All outputs are registered.

## Timing
- Reset values: gnt = 0, done = 0, err = 0, mux_sel = 4'h0, ld_en = 16'h0, mem_rd = 0, busy = 0, ptr = 0, state = IDLE.
- Reset asserted mid-transfer clears everything asynchronously. No done pulse is issued and the transfer is lost.
- req sampled high at edge t in IDLE gives:
  - gnt and busy high after t, with mux_sel valid the same cycle.
  - Non-MEM source: ld_en and done in cycle t+2; back to IDLE after t+3. That is 3 cycles per transfer, and a back-to-back grant is possible from the IDLE cycle.
  - MEM source: mem_rd in cycle t+1, LOAD in cycle t+2+MEM_LAT.
- mux_sel is stable from SEL through LOAD, so bus data is valid at the LOAD edge.
- Simultaneous requests: exactly one gnt bit is ever high. Priority order is ptr, ptr+1, ..., wrapping at NREQ-1 -> 0.

## Test plan
- Single request: req = 4'b0010, slot1 src = 14 (AC), dst = 2 (DR) -> gnt = 0010 one cycle later, mux_sel = 14, ld_en = 16'h0004 and done = 0010 two cycles after sampling, busy low on the next cycle.
- MEM read with MEM_LAT = 2: slot0 src = 0, dst = 1 -> mem_rd pulses in SEL, 2 WAIT cycles, ld_en = 16'h0002 at cycle t+4, no err.
- Round-robin: all four req high and held -> grant order 0, 1, 2, 3, 0. Each done is a single pulse, and gnt is always one-hot.
- Illegal transfers: src = dst = 5, and then src = 15 -> done + err pulse, ld_en stays 0, mem_rd stays 0.
- Reset mid-WAIT: assert Rst during the MEM wait -> all outputs 0 immediately, no done. After release, the same req is regranted starting from ptr = 0.
- Request dropped after grant: deassert req in SEL -> transfer still completes with ld_en and done, then the arbiter returns to IDLE.
